decode_issue_ctrl: RTL and testbench

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

---
 rtl/decode_issue_ctrl_pkg.sv | 27 ++
 rtl/decode_issue_ctrl_scoreboard.sv | 77 +++++++
 rtl/decode_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_decode_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue slice.
// core_types_pkg carries the pipeline-wide value types (decoded_op_t, u32).
// pipes carries the issue FSM encoding and the architectural register count.
package core_types_pkg;
  typedef logic [31:0] u32;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_LD  = 4'd5,
    OP_ST  = 4'd6,
    OP_BR  = 4'd7
  } decoded_op_t;
endpackage

package pipes;
  localparam int NUM_ARCH_REGS = 32;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_READY  = 2'd1,
    ST_HAZARD = 2'd2
  } issue_state_t;
endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// issue_scoreboard: pending-write bitmap (always) and pending-load bitmap
// (only with DECODE_FWD_EN). The hazard flag is evaluated against the
// bitmap as it will look after this cycle's set/clear, so an issuing
// producer is seen immediately and a clearing writeback wakes a waiter
// without an extra cycle. Set wins over clear on the same register.
module issue_scoreboard
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_valid,
  input  logic [4:0] set_rd,
  input  logic       set_is_load,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       ld_done_valid,
  input  logic [4:0] ld_done_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       hazard
);
  logic [NUM_ARCH_REGS-1:0] set_mask;
  logic [NUM_ARCH_REGS-1:0] wb_mask;
  logic [NUM_ARCH_REGS-1:0] pend_wr_reg;
  logic [NUM_ARCH_REGS-1:0] pend_wr_next;
  logic [NUM_ARCH_REGS-1:0] watch;

  // x0 is hardwired: its bits are never set
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_dec
      if (gi == 0) begin : g_zero
        assign set_mask[gi] = 1'b0;
        assign wb_mask[gi]  = 1'b0;
      end else begin : g_reg
        assign set_mask[gi] = set_valid && (set_rd == 5'(gi));
        assign wb_mask[gi]  = wb_valid && (wb_rd == 5'(gi));
      end
    end
  endgenerate

  assign pend_wr_next = (pend_wr_reg & ~wb_mask) | set_mask;

  // pending-write bitmap register
  always_ff @(posedge clk) begin
    if (reset) pend_wr_reg <= '0;
    else       pend_wr_reg <= pend_wr_next;
  end

`ifdef DECODE_FWD_EN
  logic [NUM_ARCH_REGS-1:0] ld_mask;
  logic [NUM_ARCH_REGS-1:0] pend_ld_reg;
  logic [NUM_ARCH_REGS-1:0] pend_ld_next;
  logic                     unused_wr;

  assign ld_mask      = ld_done_valid ? ({{(NUM_ARCH_REGS-1){1'b0}}, 1'b1} << ld_done_rd) : '0;
  assign pend_ld_next = (pend_ld_reg & ~(wb_mask | ld_mask)) | (set_is_load ? set_mask : '0);

  // pending-load bitmap register; ALU results are forwarded so only loads block
  always_ff @(posedge clk) begin
    if (reset) pend_ld_reg <= '0;
    else       pend_ld_reg <= pend_ld_next;
  end

  assign watch     = pend_ld_next;
  assign unused_wr = ^pend_wr_next;
`else
  logic unused_ld;
  assign unused_ld = ^{set_is_load, ld_done_valid, ld_done_rd};
  assign watch     = pend_wr_next;
`endif

  assign hazard = (use_rs1 && (rs1 != 5'd0) && watch[rs1]) ||
                  (use_rs2 && (rs2 != 5'd0) && watch[rs2]);
endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: one-entry issue slot between decode and execute with
// operand hazard tracking. Optional macro DECODE_FWD_EN: ALU results are
// forwarded, so only pending loads stall a consumer.
module decode_issue_ctrl
  import core_types_pkg::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  decoded_op_t in_op,
  input  u32          in_raw,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_use_rs1,
  input  logic        in_use_rs2,
  input  logic        in_wen,
  input  logic        in_is_load,
  output logic        out_valid,
  input  logic        out_ready,
  output decoded_op_t out_op,
  output u32          out_raw,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        ld_done_valid,
  input  logic [4:0]  ld_done_rd,
  input  logic        flush,
  output logic        stall_hazard
);
  issue_state_t state_reg, state_next;
  decoded_op_t  op_reg;
  u32           raw_reg;
  logic [4:0]   rd_reg, rs1_reg, rs2_reg;
  logic         wen_reg, is_load_reg, use_rs1_reg, use_rs2_reg;
  logic         xfer, issue, hazard;
  logic [4:0]   chk_rs1, chk_rs2;
  logic         chk_use1, chk_use2;

  assign out_valid    = (state_reg == ST_READY);
  assign stall_hazard = (state_reg == ST_HAZARD);
  // flush blocks capture so a squash never races a new instruction in
  assign in_ready     = !flush && ((state_reg == ST_EMPTY) || ((state_reg == ST_READY) && out_ready));
  assign xfer         = in_valid && in_ready;
  assign issue        = out_valid && out_ready;
  assign out_op       = op_reg;
  assign out_raw      = raw_reg;
  assign out_rd       = rd_reg;
  assign out_wen      = wen_reg;

  // one scoreboard query port: the waiting slot while stalled, else the incoming op
  always_comb begin
    chk_rs1  = in_rs1;
    chk_rs2  = in_rs2;
    chk_use1 = in_use_rs1;
    chk_use2 = in_use_rs2;
    if (state_reg == ST_HAZARD) begin
      chk_rs1  = rs1_reg;
      chk_rs2  = rs2_reg;
      chk_use1 = use_rs1_reg;
      chk_use2 = use_rs2_reg;
    end
  end

  issue_scoreboard u_sb (
    .clk           (clk),
    .reset         (reset),
    .set_valid     (issue && wen_reg),
    .set_rd        (rd_reg),
    .set_is_load   (is_load_reg),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .ld_done_valid (ld_done_valid),
    .ld_done_rd    (ld_done_rd),
    .rs1           (chk_rs1),
    .rs2           (chk_rs2),
    .use_rs1       (chk_use1),
    .use_rs2       (chk_use2),
    .hazard        (hazard)
  );

  // issue FSM next-state: flush, then capture, then drain, then wake-up
  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = ST_EMPTY;
    else if (xfer)
      state_next = hazard ? ST_HAZARD : ST_READY;
    else if (issue)
      state_next = ST_EMPTY;
    else if ((state_reg == ST_HAZARD) && !hazard)
      state_next = ST_READY;
  end

  // issue FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_EMPTY;
    else       state_reg <= state_next;
  end

  // instruction slot; only written on an upstream transfer so it holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= OP_NOP;
      raw_reg     <= '0;
      rd_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      wen_reg     <= 1'b0;
      is_load_reg <= 1'b0;
      use_rs1_reg <= 1'b0;
      use_rs2_reg <= 1'b0;
    end else if (xfer) begin
      op_reg      <= in_op;
      raw_reg     <= in_raw;
      rd_reg      <= in_rd;
      rs1_reg     <= in_rs1;
      rs2_reg     <= in_rs2;
      wen_reg     <= in_wen;
      is_load_reg <= in_is_load;
      use_rs1_reg <= in_use_rs1;
      use_rs2_reg <= in_use_rs2;
    end
  end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Testbench for decode_issue_ctrl: table-driven handshake vectors plus
// hand-written hazard/flush/reset sequences, with a queue scoreboard that
// checks every issued instruction. Honours DECODE_FWD_EN if defined.
`timescale 1ns/1ps
module tb_decode_issue_ctrl;
  import core_types_pkg::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  decoded_op_t in_op;
  u32          in_raw;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_wen, in_is_load;
  logic        out_valid, out_ready;
  decoded_op_t out_op;
  u32          out_raw;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        wb_valid, ld_done_valid, flush, stall_hazard;
  logic [4:0]  wb_rd, ld_done_rd;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_raw(in_raw),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wen(in_wen), .in_is_load(in_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_raw(out_raw),
    .out_rd(out_rd), .out_wen(out_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd),
    .flush(flush), .stall_hazard(stall_hazard)
  );

  typedef struct {
    decoded_op_t op;
    u32          raw;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  typedef struct {
    logic        v;
    decoded_op_t op;
    u32          raw;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wen, ordy;
    logic        e_in_ready, e_out_valid;
    u32          e_raw;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_op = OP_NOP; in_raw = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wen = 1'b0; in_is_load = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    ld_done_valid = 1'b0; ld_done_rd = '0; flush = 1'b0;
  endtask

  task automatic instr(input decoded_op_t op, input u32 raw, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld);
    in_valid = 1'b1; in_op = op; in_raw = raw;
    in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_wen = wen; in_is_load = ld;
  endtask

  task automatic clear_load(input logic [4:0] rd);
`ifdef DECODE_FWD_EN
    ld_done_valid = 1'b1; ld_done_rd = rd;
`else
    wb_valid = 1'b1; wb_rd = rd;
`endif
  endtask

  // scoreboard update for the current cycle, then advance to the next negedge
  task automatic step();
    exp_t e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: got issue raw=%h expected none", out_raw);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] issue op=%0d raw=%h rd=%0d wen=%0b", out_op, out_raw, out_rd, out_wen);
          chk("issue_op", 32'(out_op), 32'(e.op));
          chk("issue_raw", out_raw, e.raw);
          chk("issue_rd", 32'(out_rd), 32'(e.rd));
          chk("issue_wen", 32'(out_wen), 32'(e.wen));
        end
      end
      if (flush) sb_q.delete();
      if (in_valid && in_ready) begin
        e.op = in_op; e.raw = in_raw; e.rd = in_rd; e.wen = in_wen;
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input decoded_op_t op, input u32 raw,
                              input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic wen,
                              input logic ordy, input logic eir, input logic eov, input u32 eraw);
    vec_t r;
    r.v = v; r.op = op; r.raw = raw; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.wen = wen; r.ordy = ordy;
    r.e_in_ready = eir; r.e_out_valid = eov; r.e_raw = eraw;
    return r;
  endfunction

  vec_t vt[13];

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // independent instructions: sources never written, so no hazards
    vt[0]  = mk(1, OP_ADD, 32'hA000_0000, 1, 1, 2, 1, 10, 1, 1, 1, 0, 32'h0);
    vt[1]  = mk(1, OP_SUB, 32'hA000_0001, 3, 1, 0, 0, 11, 1, 1, 1, 1, 32'hA000_0000);
    vt[2]  = mk(1, OP_AND, 32'hA000_0002, 1, 0, 4, 1, 12, 1, 0, 0, 1, 32'hA000_0001);
    vt[3]  = mk(1, OP_AND, 32'hA000_0002, 1, 0, 4, 1, 12, 1, 0, 0, 1, 32'hA000_0001);
    vt[4]  = mk(1, OP_AND, 32'hA000_0002, 1, 0, 4, 1, 12, 1, 0, 0, 1, 32'hA000_0001);
    vt[5]  = mk(1, OP_AND, 32'hA000_0002, 1, 0, 4, 1, 12, 1, 1, 1, 1, 32'hA000_0001);
    vt[6]  = mk(0, OP_NOP, 32'h0,         0, 0, 0, 0, 0,  0, 1, 1, 1, 32'hA000_0002);
    vt[7]  = mk(0, OP_NOP, 32'h0,         0, 0, 0, 0, 0,  0, 1, 1, 0, 32'h0);
    vt[8]  = mk(1, OP_OR,  32'hA000_0003, 1, 1, 0, 0, 0,  1, 0, 1, 0, 32'h0);
    vt[9]  = mk(1, OP_ADD, 32'hA000_0004, 0, 1, 0, 0, 13, 1, 1, 1, 1, 32'hA000_0003);
    vt[10] = mk(1, OP_SUB, 32'hA000_0005, 2, 1, 0, 1, 14, 1, 1, 1, 1, 32'hA000_0004);
    vt[11] = mk(0, OP_NOP, 32'h0,         0, 0, 0, 0, 0,  0, 1, 1, 1, 32'hA000_0005);
    vt[12] = mk(0, OP_NOP, 32'h0,         0, 0, 0, 0, 0,  0, 1, 1, 0, 32'h0);

    do_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_hazard, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_out_raw", out_raw, 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_out_wen", 32'(out_wen), 0);
    @(negedge clk);

    // table: back-to-back issue, 3-cycle backpressure, x0 producer/consumer
    for (int i = 0; i < 13; i++) begin
      drive_idle();
      if (vt[i].v) instr(vt[i].op, vt[i].raw, vt[i].rs1, vt[i].u1, vt[i].rs2, vt[i].u2,
                         vt[i].rd, vt[i].wen, 1'b0);
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 32'(vt[i].e_in_ready));
      chk($sformatf("vec%0d_out_valid", i), out_valid, 32'(vt[i].e_out_valid));
      chk($sformatf("vec%0d_stall", i), stall_hazard, 0);
      if (vt[i].e_out_valid) chk($sformatf("vec%0d_out_raw", i), out_raw, vt[i].e_raw);
      step();
    end

    // ALU producer then dependent consumer
    do_reset();
    drive_idle(); instr(OP_ADD, 32'hB000_0001, 0, 0, 0, 0, 5, 1, 0); #1;
    chk("a_in_ready", in_ready, 1); step();
    drive_idle(); instr(OP_ADD, 32'hB000_0002, 5, 1, 0, 0, 6, 1, 0); #1;
    chk("a_prod_issue", out_valid, 1); chk("a_cons_accept", in_ready, 1); step();
    drive_idle(); #1;
`ifdef DECODE_FWD_EN
    chk("a_fwd_no_stall", stall_hazard, 0); chk("a_fwd_b2b", out_valid, 1); step();
`else
    chk("a_stall", stall_hazard, 1); chk("a_held", out_valid, 0); step();
    drive_idle(); wb_valid = 1'b1; wb_rd = 5'd4; #1;
    chk("a_other_wb_stall", stall_hazard, 1); step();
    drive_idle(); wb_valid = 1'b1; wb_rd = 5'd5; #1;
    chk("a_wb_cycle_stall", stall_hazard, 1); step();
    drive_idle(); #1;
    chk("a_wake_valid", out_valid, 1); chk("a_wake_stall", stall_hazard, 0); step();
`endif
    drive_idle(); #1; chk("a_drained", out_valid, 0); step();

    // load producer then dependent consumer
    do_reset();
    drive_idle(); instr(OP_LD, 32'hC000_0001, 1, 1, 0, 0, 7, 1, 1); #1; step();
    drive_idle(); instr(OP_ADD, 32'hC000_0002, 7, 1, 3, 1, 8, 1, 0); #1;
    chk("b_ld_issue", out_valid, 1); chk("b_cons_accept", in_ready, 1); step();
    drive_idle(); #1;
    chk("b_stall", stall_hazard, 1); chk("b_held", out_valid, 0); chk("b_in_ready", in_ready, 0); step();
    drive_idle(); wb_valid = 1'b1; wb_rd = 5'd3; ld_done_valid = 1'b1; ld_done_rd = 5'd3; #1;
    chk("b_other_clear_stall", stall_hazard, 1); step();
    drive_idle(); clear_load(5'd7); #1;
    chk("b_clear_cycle_stall", stall_hazard, 1); step();
    drive_idle(); #1;
    chk("b_wake_valid", out_valid, 1); chk("b_wake_stall", stall_hazard, 0); step();
    drive_idle(); #1; chk("b_drained", out_valid, 0); step();

    // flush while stalled, with a competing upstream instruction
    do_reset();
    drive_idle(); instr(OP_LD, 32'hD000_0001, 0, 0, 0, 0, 20, 1, 1); #1; step();
    drive_idle(); instr(OP_ADD, 32'hD000_0002, 20, 1, 0, 0, 21, 1, 0); #1;
    chk("c_ld_issue", out_valid, 1); step();
    drive_idle(); #1; chk("c_stall", stall_hazard, 1); step();
    drive_idle(); flush = 1'b1; instr(OP_SUB, 32'hD000_0003, 0, 0, 0, 0, 22, 1, 0); #1;
    chk("c_flush_in_ready", in_ready, 0); step();
    drive_idle(); #1;
    chk("c_post_valid", out_valid, 0); chk("c_post_stall", stall_hazard, 0);
    chk("c_post_in_ready", in_ready, 1); step();
    drive_idle(); instr(OP_OR, 32'hD000_0004, 0, 0, 20, 1, 23, 1, 0); #1; step();
    drive_idle(); #1; chk("c_bit_kept", stall_hazard, 1); step();
    drive_idle(); wb_valid = 1'b1; wb_rd = 5'd20; #1; step();
    drive_idle(); #1;
    chk("c_wake_valid", out_valid, 1); chk("c_wake_raw", out_raw, 32'hD000_0004); step();
    drive_idle(); #1; chk("c_drained", out_valid, 0); step();

    // set beats same-cycle writeback; reset mid-stall clears everything
    do_reset();
    drive_idle(); instr(OP_LD, 32'hE000_0001, 0, 0, 0, 0, 9, 1, 1); #1; step();
    drive_idle(); instr(OP_ADD, 32'hE000_0002, 9, 1, 0, 0, 10, 1, 0);
    wb_valid = 1'b1; wb_rd = 5'd9; #1;
    chk("d_ld_issue", out_valid, 1); step();
    drive_idle(); #1; chk("d_set_wins", stall_hazard, 1); step();
    drive_idle(); #1; chk("d_still_stall", stall_hazard, 1); step();
    drive_idle(); reset = 1'b1; flush = 1'b1;
    instr(OP_SUB, 32'hE000_0003, 0, 0, 0, 0, 11, 1, 0); #1; step();
    reset = 1'b0; drive_idle(); #1;
    chk("d_rst_stall", stall_hazard, 0); chk("d_rst_valid", out_valid, 0);
    chk("d_rst_in_ready", in_ready, 1); chk("d_rst_raw", out_raw, 0);
    chk("d_rst_rd", 32'(out_rd), 0); chk("d_rst_wen", 32'(out_wen), 0);
    chk("d_rst_op", 32'(out_op), 0); step();
    drive_idle(); instr(OP_ADD, 32'hE000_0004, 9, 1, 0, 0, 10, 1, 0); #1; step();
    drive_idle(); #1;
    chk("d_bits_cleared", stall_hazard, 0); chk("d_cons_valid", out_valid, 1);
    chk("d_cons_raw", out_raw, 32'hE000_0004); step();
    drive_idle(); #1; chk("d_drained", out_valid, 0); step();

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
